// File: rtl/tt_array_multiplier_hhrb98_pkg.sv
// rtl/tt_array_multiplier_hhrb98_pkg.sv - shared operand/product types for the 4x4 array multiplier
package tt_array_multiplier_hhrb98_pkg;

  typedef logic [3:0] operand_t;
  typedef logic [7:0] product_t;

  // ui_in packs operand B in the upper nibble and operand A in the lower nibble
  typedef struct packed {
    operand_t b;
    operand_t a;
  } operands_t;

endpackage

// File: rtl/tt_array_multiplier_hhrb98_if.sv
// rtl/tt_array_multiplier_hhrb98_if.sv - Tiny Tapeout pin bundle for the array multiplier
interface tt_array_multiplier_hhrb98_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/tt_array_multiplier_hhrb98_full_adder.sv
// rtl/tt_array_multiplier_hhrb98_full_adder.sv - single full-adder cell of the multiplier array
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/tt_array_multiplier_hhrb98.sv
// rtl/tt_array_multiplier_hhrb98.sv - 4x4 unsigned ripple-carry array multiplier with registered product
module tt_array_multiplier_hhrb98
  import tt_array_multiplier_hhrb98_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  tt_array_multiplier_hhrb98_if.slave   bus
);

  localparam int N  = 4;
  localparam int PW = 8;

  operands_t           ops;
  logic [N-1:0]        pp [N];
  logic [N:0]          r1, r2, r3;
  logic                c1_0, c1_1, c1_2;
  logic                c2_0, c2_1, c2_2;
  logic                c3_0, c3_1, c3_2;
  logic [PW-1:0]       product;
  product_t            prod_q;
  logic                unused_uio;

  assign ops = operands_t'(bus.ui_in);

  for (genvar i = 0; i < N; i++) begin : g_pp_row
    for (genvar j = 0; j < N; j++) begin : g_pp_col
      assign pp[i][j] = ops.a[j] & ops.b[i];
    end
  end

  // Each row adds pp[i] to the upper bits of the running sum; carries ripple within the row
  full_adder u_r1_0 (.a(pp[1][0]), .b(pp[0][1]), .cin(1'b0), .s(r1[0]), .cout(c1_0));
  full_adder u_r1_1 (.a(pp[1][1]), .b(pp[0][2]), .cin(c1_0), .s(r1[1]), .cout(c1_1));
  full_adder u_r1_2 (.a(pp[1][2]), .b(pp[0][3]), .cin(c1_1), .s(r1[2]), .cout(c1_2));
  full_adder u_r1_3 (.a(pp[1][3]), .b(1'b0),     .cin(c1_2), .s(r1[3]), .cout(r1[4]));

  full_adder u_r2_0 (.a(pp[2][0]), .b(r1[1]),    .cin(1'b0), .s(r2[0]), .cout(c2_0));
  full_adder u_r2_1 (.a(pp[2][1]), .b(r1[2]),    .cin(c2_0), .s(r2[1]), .cout(c2_1));
  full_adder u_r2_2 (.a(pp[2][2]), .b(r1[3]),    .cin(c2_1), .s(r2[2]), .cout(c2_2));
  full_adder u_r2_3 (.a(pp[2][3]), .b(r1[4]),    .cin(c2_2), .s(r2[3]), .cout(r2[4]));

  full_adder u_r3_0 (.a(pp[3][0]), .b(r2[1]),    .cin(1'b0), .s(r3[0]), .cout(c3_0));
  full_adder u_r3_1 (.a(pp[3][1]), .b(r2[2]),    .cin(c3_0), .s(r3[1]), .cout(c3_1));
  full_adder u_r3_2 (.a(pp[3][2]), .b(r2[3]),    .cin(c3_1), .s(r3[2]), .cout(c3_2));
  full_adder u_r3_3 (.a(pp[3][3]), .b(r2[4]),    .cin(c3_2), .s(r3[3]), .cout(r3[4]));

  assign product = {r3, r2[0], r1[0], pp[0][0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (bus.ena) begin
      prod_q <= product;
    end
  end

  assign bus.uo_out  = prod_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  assign unused_uio = ^bus.uio_in;

endmodule

// File: tb/tb_tt_array_multiplier_hhrb98.sv
// tb/tb_tt_array_multiplier_hhrb98.sv - directed self-checking bench for the array multiplier
module tb_tt_array_multiplier_hhrb98;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  tt_array_multiplier_hhrb98_if bus ();

  tt_array_multiplier_hhrb98 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'hFF;
    bus.uio_in = 8'hA5;
    #2;
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_before_edge: got %h want 00", bus.uo_out);
    end
    step();
    step();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_after_edges: got %h want 00", bus.uo_out);
    end
    checks++;
    if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL reset_uio: got out=%h oe=%h want 00/00", bus.uio_out, bus.uio_oe);
    end
    bus.ena = 1'b0;
    rst_n   = 1'b1;
    step();
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_no_ena: got %h want 00", bus.uo_out);
    end
  endtask

  task automatic test_basic();
    bus.ena   = 1'b1;
    bus.ui_in = 8'h53;
    step();
    checks++;
    if (bus.uo_out !== 8'h0F) begin
      errors++;
      $display("FAIL basic_3x5: got %h want 0F", bus.uo_out);
    end
    bus.ui_in = 8'h5C;
    step();
    checks++;
    if (bus.uo_out !== 8'h3C) begin
      errors++;
      $display("FAIL basic_12x5: got %h want 3C", bus.uo_out);
    end
  endtask

  task automatic test_corners();
    logic [7:0] vin [5];
    logic [7:0] vexp [5];
    vin[0] = 8'hFF; vexp[0] = 8'hE1;
    vin[1] = 8'h0F; vexp[1] = 8'h00;
    vin[2] = 8'hF0; vexp[2] = 8'h00;
    vin[3] = 8'h11; vexp[3] = 8'h01;
    vin[4] = 8'h88; vexp[4] = 8'h40;
    bus.ena = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.ui_in = vin[k];
      step();
      checks++;
      if (bus.uo_out !== vexp[k]) begin
        errors++;
        $display("FAIL corner_%h: got %h want %h", vin[k], bus.uo_out, vexp[k]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] v;
    logic [7:0] want;
    bus.ena = 1'b1;
    for (int k = 0; k < 256; k++) begin
      v          = 8'(k);
      want       = 8'(int'(v[3:0]) * int'(v[7:4]));
      bus.ui_in  = v;
      bus.uio_in = ~v;
      step();
      checks++;
      if (bus.uo_out !== want) begin
        errors++;
        $display("FAIL exhaustive_%h: got %h want %h", v, bus.uo_out, want);
      end
      checks++;
      if (bus.uio_out !== 8'h00 || bus.uio_oe !== 8'h00) begin
        errors++;
        $display("FAIL exhaustive_uio_%h: got out=%h oe=%h want 00/00", v, bus.uio_out, bus.uio_oe);
      end
    end
  endtask

  task automatic test_hold();
    bus.ena   = 1'b1;
    bus.ui_in = 8'hFF;
    step();
    checks++;
    if (bus.uo_out !== 8'hE1) begin
      errors++;
      $display("FAIL hold_load: got %h want E1", bus.uo_out);
    end
    bus.ena   = 1'b0;
    bus.ui_in = 8'h23;
    step();
    step();
    checks++;
    if (bus.uo_out !== 8'hE1) begin
      errors++;
      $display("FAIL hold_keep: got %h want E1", bus.uo_out);
    end
    bus.ena = 1'b1;
    step();
    checks++;
    if (bus.uo_out !== 8'h06) begin
      errors++;
      $display("FAIL hold_resume: got %h want 06", bus.uo_out);
    end
  endtask

  task automatic test_async_reset();
    bus.ena   = 1'b1;
    bus.ui_in = 8'hFF;
    step();
    checks++;
    if (bus.uo_out !== 8'hE1) begin
      errors++;
      $display("FAIL async_preload: got %h want E1", bus.uo_out);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL async_clear: got %h want 00", bus.uo_out);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL async_released: got %h want 00", bus.uo_out);
    end
    bus.ui_in = 8'h53;
    step();
    checks++;
    if (bus.uo_out !== 8'h0F) begin
      errors++;
      $display("FAIL async_recover: got %h want 0F", bus.uo_out);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_corners();
    test_exhaustive();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
